// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter
// Shares a single-ported, asynchronous-read data memory between the CPU
// load/store path (port 0) and a secondary master (port 1).
// Each access takes two cycles: a grant cycle and a one-cycle ACCESS state.
// Build option: define DMEM_ARB_ROUND_ROBIN_EN for round-robin arbitration
// on simultaneous requests. Otherwise port 0 has fixed priority.
//
// Handshake: i_reqN is held, with i_weN/i_addrN/i_wdataN stable, until o_ackN
// pulses for one cycle. The requester must drop or change i_reqN by the cycle
// after o_ackN. For reads, o_rvalidN pulses one cycle after o_ackN, and o_rdata
// is valid in that cycle. o_rdata then holds until the next read completes.
module data_memory_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_ack0,
    output logic              o_ack1,
    output logic              o_rvalid0,
    output logic              o_rvalid1,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_state      // debug: 0 = IDLE, 1 = ACCESS
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t              r_state;
    logic                r_cmd_we;
    logic                r_cmd_port;   // granted port of the command in flight
    logic [ADDR_W-1:0]   r_cmd_addr;
    logic [DATA_W-1:0]   r_cmd_wdata;
    logic                r_ack0;
    logic                r_ack1;
    logic                r_rvalid0;
    logic                r_rvalid1;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_any_req;
    logic                w_sel1;       // 1 = port 1 wins this arbitration

    assign w_any_req = i_req0 | i_req1;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // 1 = port 1 was granted last, so port 0 wins the next tie
    logic r_last_grant;
    assign w_sel1 = i_req1 & (~i_req0 | ~r_last_grant);
`else
    assign w_sel1 = i_req1 & ~i_req0;
`endif

    // Arbitration FSM: grant in IDLE, perform the memory access in ACCESS
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_cmd_we    <= 1'b0;
            r_cmd_port  <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_rdata     <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_cmd_port  <= w_sel1;
                        r_cmd_we    <= w_sel1 ? i_we1    : i_we0;
                        r_cmd_addr  <= w_sel1 ? i_addr1  : i_addr0;
                        r_cmd_wdata <= w_sel1 ? i_wdata1 : i_wdata0;
                        r_ack0      <= ~w_sel1;
                        r_ack1      <= w_sel1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                        r_last_grant <= w_sel1;
`endif
                        r_state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!r_cmd_we) begin
                        r_rdata   <= i_mem_rdata;
                        r_rvalid0 <= ~r_cmd_port;
                        r_rvalid1 <= r_cmd_port;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The write strobe is gated by the state, so an async reset during ACCESS drops it at once.
    assign o_mem_we    = r_cmd_we & (r_state == ST_ACCESS);
    assign o_mem_addr  = r_cmd_addr;
    assign o_mem_wdata = r_cmd_wdata;
    assign o_ack0      = r_ack0;
    assign o_ack1      = r_ack1;
    assign o_rvalid0   = r_rvalid0;
    assign o_rvalid1   = r_rvalid1;
    assign o_rdata     = r_rdata;
    assign o_state     = (r_state == ST_ACCESS);

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Testbench for data_memory_arbiter.
// The reference model is transaction-level. It holds the last-granted port,
// a shadow memory, and a queue of expected read data. It predicts the winner,
// the memory command, and the read data for each request.
module tb_data_memory_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    // ---------------- DUT ----------------
    logic              req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
    logic              ack0, ack1, rvalid0, rvalid1, mem_we, state_dbg;
    logic [DATA_W-1:0] rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;

    data_memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_ack0(ack0), .o_ack1(ack1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
        .o_rdata(rdata), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_state(state_dbg)
    );

    // ---------------- memory (environment) ----------------
    logic [DATA_W-1:0] tb_mem [0:255];
    initial for (int i = 0; i < 256; i++) tb_mem[i] = '0;
    always @(posedge clk) if (mem_we) tb_mem[mem_addr[7:0]] <= mem_wdata;
    assign mem_rdata = tb_mem[mem_addr[7:0]];

    // ---------------- scoreboard / reference model ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] ref_mem [int];
    int                last_grant = 1;       // port 0 wins the first tie
    logic [DATA_W-1:0] exp_rdata = '0;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] ref_read(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    function automatic int pick_winner(input bit r0, input bit r1);
        if (r0 && r1) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            return (last_grant == 1) ? 0 : 1;
`else
            return 0;
`endif
        end
        return r1 ? 1 : 0;
    endfunction

    // ---------------- driver ----------------
    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
    task automatic run_txn(input bit r0, input bit r1, input bit w0, input bit w1,
                           input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                           input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                           output int ack_cyc);
        int win;
        bit we;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        req0 = r0; req1 = r1; we0 = w0; we1 = w1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        win = pick_winner(r0, r1);
        we  = (win == 0) ? w0 : w1;
        a   = (win == 0) ? a0 : a1;
        d   = (win == 0) ? d0 : d1;
        @(posedge clk); #1;
        ack_cyc = cyc;
        check("ack0",      {31'b0, ack0},      {31'b0, win == 0});
        check("ack1",      {31'b0, ack1},      {31'b0, win == 1});
        check("state_acc", {31'b0, state_dbg}, 32'd1);
        check("mem_we",    {31'b0, mem_we},    {31'b0, we});
        check("mem_addr",  mem_addr,           a);
        if (we) check("mem_wdata", mem_wdata, d);
        req0 = 0; req1 = 0;
        last_grant = win;
        if (we) ref_mem[int'(a)] = d;
        else    exp_q.push_back(ref_read(int'(a)));
        @(posedge clk); #1;
        check("rvalid0",    {31'b0, rvalid0},   {31'b0, !we && win == 0});
        check("rvalid1",    {31'b0, rvalid1},   {31'b0, !we && win == 1});
        check("ack_clear",  {30'b0, ack1, ack0}, 32'd0);
        check("mem_we_off", {31'b0, mem_we},    32'd0);
        check("state_idle", {31'b0, state_dbg}, 32'd0);
        if (!we && exp_q.size() > 0) exp_rdata = exp_q.pop_front();
        check("rdata", rdata, exp_rdata);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_acks"},   {28'b0, ack0, ack1, rvalid0, rvalid1}, 32'd0);
        check({tag, "_mem_we"}, {31'b0, mem_we},    32'd0);
        check({tag, "_rdata"},  rdata,              32'd0);
        check({tag, "_maddr"},  mem_addr,           32'd0);
        check({tag, "_mwdata"}, mem_wdata,          32'd0);
        check({tag, "_state"},  {31'b0, state_dbg}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0, c1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1;

        // Port 0 write, then port 1 reads it back
        run_txn(1, 0, 1, 0, 32'h04, 32'h0, 32'h0000_00AA, 32'h0, c0);
        run_txn(0, 1, 0, 0, 32'h0, 32'h04, 32'h0, 32'h0, c0);
        check("tb_mem_04", tb_mem[8'h04], 32'h0000_00AA);

        // Port 0 read of unwritten location
        run_txn(1, 0, 0, 0, 32'h08, 32'h0, 32'h0, 32'h0, c0);

        // Both ports requesting reads continuously
        for (int i = 0; i < 6; i++)
            run_txn(1, 1, 0, 0, 32'h04, 32'h08, 32'h0, 32'h0, c0);

        // Back-to-back port 1 writes
        run_txn(0, 1, 0, 1, 32'h0, 32'h10, 32'h0, 32'h1111_0010, c0);
        run_txn(0, 1, 0, 1, 32'h0, 32'h11, 32'h0, 32'h2222_0011, c1);
        check("ack1_spacing", c1 - c0, 32'd2);
        check("tb_mem_10", tb_mem[8'h10], 32'h1111_0010);
        check("tb_mem_11", tb_mem[8'h11], 32'h2222_0011);

        // Reset during ACCESS of a write of 0x55 to 0x20
        req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'h55; req1 = 0;
        @(posedge clk); #1;
        check("rst_pre_we", {31'b0, mem_we}, 32'd1);
        req0 = 0; we0 = 0;
        #2 rst_n = 0;
        #1;
        check("rst_we_drop", {31'b0, mem_we}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        #1;
        check_reset_outputs("post_rst");
        check("tb_mem_20", tb_mem[8'h20], 32'h0);
        last_grant = 1;
        exp_rdata  = '0;
        exp_q.delete();
        @(posedge clk); #1;

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            bit r0, r1;
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1;
            run_txn(r0, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    32'($urandom_range(0, 31)), 32'($urandom_range(0, 31)),
                    $urandom, $urandom, c0);
        end

        // Final memory contents against the shadow memory
        for (int a = 0; a < 32; a++) check("final_mem", tb_mem[a], ref_read(a));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
